send_ack_arbiter: RTL and testbench

//   Shares one 4-phase send/ack channel (the CPU_async-style handshake) among N_REQ

---
 rtl/send_ack_arbiter.sv | 142 ++++++++++++++
 tb/tb_send_ack_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/send_ack_arbiter.sv
// send_ack_arbiter: round-robin arbiter sharing one 4-phase send/ack channel.
// Optional ack timeout with abort flag: define SEND_ACK_ARB_TIMEOUT_EN.
module send_ack_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int TO_CYCLES = 255,
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        done,
    output logic [IW-1:0]           grant_id,
    output logic                    busy,
    output logic                    send,
    output logic [DATA_W-1:0]       data_out,
    input  logic                    ack
`ifdef SEND_ACK_ARB_TIMEOUT_EN
    ,
    output logic                    timeout_err
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RELEASE,
        DONE
    } state_t;

    state_t            state;
    logic [IW-1:0]     ptr;
    logic              ack_m;
    logic              ack_s;
    logic              found;
    logic [IW-1:0]     pick;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] words [N_REQ];

    if (N_REQ < 2 || N_REQ > 8 || TO_CYCLES < 1 || TO_CYCLES > 65535)
    begin : g_cfg_out_of_range
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_words
        assign words[i] = req_data[i*DATA_W +: DATA_W];
    end

    // First set request at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IW'((int'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

`ifdef SEND_ACK_ARB_TIMEOUT_EN
    logic [15:0] cnt;
    logic        abort;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_m    <= 1'b0;
            ack_s    <= 1'b0;
            state    <= IDLE;
            ptr      <= '0;
            grant_id <= '0;
            data_out <= '0;
            busy     <= 1'b0;
            send     <= 1'b0;
            done     <= '0;
`ifdef SEND_ACK_ARB_TIMEOUT_EN
            cnt         <= '0;
            abort       <= 1'b0;
            timeout_err <= 1'b0;
`endif
        end else begin
            ack_m <= ack;
            ack_s <= ack_m;
            done  <= '0;
            unique case (state)
                IDLE: begin
                    if (found && !ack_s) begin
                        grant_id <= pick;
                        data_out <= words[pick];
                        busy     <= 1'b1;
                        send     <= 1'b1;
                        state    <= SEND;
`ifdef SEND_ACK_ARB_TIMEOUT_EN
                        cnt      <= '0;
                        abort    <= 1'b0;
`endif
                    end
                end
                SEND: begin
                    if (ack_s) begin
                        send  <= 1'b0;
                        state <= RELEASE;
                    end
`ifdef SEND_ACK_ARB_TIMEOUT_EN
                    else if (cnt == 16'(TO_CYCLES - 1)) begin
                        send  <= 1'b0;
                        abort <= 1'b1;
                        state <= RELEASE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
`endif
                end
                RELEASE: begin
                    if (!ack_s) begin
                        done  <= N_REQ'(1) << grant_id;
                        state <= DONE;
`ifdef SEND_ACK_ARB_TIMEOUT_EN
                        timeout_err <= abort;
`endif
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (grant_id == IW'(N_REQ - 1))
                        ptr <= '0;
                    else
                        ptr <= grant_id + IW'(1);
`ifdef SEND_ACK_ARB_TIMEOUT_EN
                    timeout_err <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_send_ack_arbiter.sv
// tb_send_ack_arbiter: scoreboard bench for the round-robin send/ack arbiter.
// Timeout scenario is built only with SEND_ACK_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_send_ack_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 20;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   done;
    logic [1:0]     grant_id;
    logic           busy;
    logic           send;
    logic [W-1:0]   data_out;
    logic           ack = 1'b0;
`ifdef SEND_ACK_ARB_TIMEOUT_EN
    logic           timeout_err;
`endif

    send_ack_arbiter #(
        .N_REQ(N),
        .DATA_W(W),
        .TO_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .done(done),
        .grant_id(grant_id),
        .busy(busy),
        .send(send),
        .data_out(data_out),
        .ack(ack)
`ifdef SEND_ACK_ARB_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       to;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    logic active = 1'b0;
    logic send_q = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   ndone  = 0;
    int   peer_mode = 0;
    logic [2:0] hist = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] d,
                        input logic to);
        exp_t e;
        e.id   = id;
        e.data = d;
        e.to   = to;
        q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int tgt;
        int c;
        tgt = ndone + n;
        c = 0;
        while (ndone < tgt && c < budget) begin
            tick();
            c++;
        end
        check(tag, 32'(ndone >= tgt), 1);
    endtask

    task automatic wait_send(input int budget, input string tag);
        int c;
        c = 0;
        while (!send && c < budget) begin
            tick();
            c++;
        end
        check(tag, 32'(send), 1);
    endtask

    // Peer: 0 = follows send delayed, 1 = ack stuck high, 2 = silent.
    always @(negedge clk) begin
        if (peer_mode == 0) begin
            hist = {hist[1:0], send};
            ack  = hist[2];
        end else begin
            hist = '0;
            ack  = (peer_mode == 1);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            active = 1'b0;
            send_q = 1'b0;
        end else begin
            if (send && !send_q) begin
                if (q.size() == 0) begin
                    check("unexpected_grant", 1, 0);
                end else begin
                    cur    = q.pop_front();
                    active = 1'b1;
                    check("grant_id", 32'(grant_id), 32'(cur.id));
                    check("grant_data", 32'(data_out), 32'(cur.data));
                end
            end else if (active && send) begin
                check("data_hold", 32'(data_out), 32'(cur.data));
            end
            if (done != '0) begin
                check("done_vec", 32'(done),
                      active ? (32'd1 << cur.id) : 32'd0);
`ifdef SEND_ACK_ARB_TIMEOUT_EN
                check("timeout_err", 32'(timeout_err),
                      active ? 32'(cur.to) : 32'd0);
`endif
                check("busy_at_done", 32'(busy), 1);
                active = 1'b0;
                ndone++;
            end
`ifdef SEND_ACK_ARB_TIMEOUT_EN
            else if (timeout_err) begin
                check("stray_timeout_err", 1, 0);
            end
`endif
            send_q = send;
        end
    end

    initial begin
        int c;
        req_data = {8'hC3, 8'hC2, 8'hA5, 8'hC0};

        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_send", 32'(send), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_done", 32'(done), 0);
            check("rst_data", 32'(data_out), 0);
        end
        check("rst_grant_id", 32'(grant_id), 0);
        rst = 1'b1;

        push(2'd1, 8'hA5, 1'b0);
        req = 4'b0010;
        wait_done(1, 60, "t2_done");
        req = '0;
        check("t2_grant_id", 32'(grant_id), 1);
        check("t2_data", 32'(data_out), 32'h A5);
        repeat (3) tick();
        check("t2_idle_busy", 32'(busy), 0);

        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        push(2'd0, 8'hC0, 1'b0);
        push(2'd1, 8'hA5, 1'b0);
        push(2'd2, 8'hC2, 1'b0);
        push(2'd3, 8'hC3, 1'b0);
        push(2'd0, 8'hC0, 1'b0);
        req = 4'b1111;
        wait_done(5, 200, "t3_done");
        req = '0;
        repeat (3) tick();
        check("t3_queue_empty", 32'(q.size()), 0);

        peer_mode = 1;
        repeat (4) tick();
        push(2'd0, 8'hC0, 1'b0);
        req = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t4_no_send", 32'(send), 0);
        end
        peer_mode = 0;
        c = 0;
        while (!send && c < 20) begin
            tick();
            c++;
        end
        check("t4_ack_gap", 32'(c >= 2), 1);
        check("t4_sent", 32'(send), 1);
        wait_done(1, 60, "t4_done");
        req = '0;
        repeat (3) tick();

        peer_mode = 2;
        push(2'd3, 8'hC3, 1'b0);
        req = 4'b1001;
        wait_send(20, "t5_sent");
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("t5_send", 32'(send), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_done", 32'(done), 0);
        check("t5_grant_id", 32'(grant_id), 0);
        check("t5_data", 32'(data_out), 0);
        push(2'd0, 8'hC0, 1'b0);
        peer_mode = 0;
        tick();
        rst = 1'b1;
        wait_done(1, 80, "t5_regrant_done");
        req = '0;
        repeat (3) tick();

`ifdef SEND_ACK_ARB_TIMEOUT_EN
        peer_mode = 2;
        push(2'd1, 8'hA5, 1'b1);
        push(2'd0, 8'hC0, 1'b0);
        req = 4'b0011;
        wait_send(20, "t6_sent");
        c = 0;
        while (send && c < 40) begin
            tick();
            c++;
        end
        check("t6_send_width", 32'(c), 32'(TO));
        wait_done(1, 20, "t6_to_done");
        peer_mode = 0;
        wait_done(1, 80, "t6_next_done");
        req = '0;
        repeat (3) tick();
`endif

        repeat (5) tick();
        check("end_queue_empty", 32'(q.size()), 0);
        check("end_busy", 32'(busy), 0);
        check("end_send", 32'(send), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
